// File: rtl/fifo_pkg.sv
// Shared pointer helpers for both sides of the asynchronous FIFO.
// Functions work on 32-bit values and are sized down with a cast at the call site.
package fifo_pkg;

  localparam int MAX_PTR_W = 32;

  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Zero upper bits leave the result unchanged, so narrow pointers can be zero-extended.
  function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] gray);
    logic [MAX_PTR_W-1:0] bin;
    bin = '0;
    bin[MAX_PTR_W-1] = gray[MAX_PTR_W-1];
    for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational gray-to-binary converter for a synchronised pointer.
// Zero latency; no flow control.
module fifo_gray2bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  always_comb begin
    bin = '0;
    bin[WIDTH-1] = gray[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer and flag controller of the asynchronous FIFO, read clock domain only.
// All outputs registered; pops are accepted only while EMPTY is low.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH   = 3,
  parameter int AEMPTY_LEVEL = 1
) (
  input  logic                  R_CLK,
  input  logic                  R_RST,
  input  logic                  R_INC,
  input  logic                  CLR_UFLOW,
  input  logic [ADDR_WIDTH:0]   R_WPTR_GRAY,
  output logic [ADDR_WIDTH-1:0] R_ADDR,
  output logic [ADDR_WIDTH:0]   R_PTR_GRAY,
  output logic                  EMPTY,
  output logic                  ALMOST_EMPTY,
  output logic [ADDR_WIDTH:0]   R_LEVEL,
  output logic                  UNDERFLOW
);

  localparam int PTR_W = ptr_width(ADDR_WIDTH);
  localparam logic [PTR_W-1:0] AE_THRESH = PTR_W'(AEMPTY_LEVEL);

  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] rbin_next;
  logic [PTR_W-1:0] rgray_next;
  logic [PTR_W-1:0] wbin;
  logic [PTR_W-1:0] level_next;
  logic             pop;

  fifo_gray2bin #(
    .WIDTH (PTR_W)
  ) u_wptr_g2b (
    .gray (R_WPTR_GRAY),
    .bin  (wbin)
  );

  // Flags are computed from the post-pop pointer so they settle on the same edge as the pop.
  always_comb begin
    pop        = R_INC & ~EMPTY;
    rbin_next  = rbin + PTR_W'(pop);
    rgray_next = PTR_W'(bin2gray(MAX_PTR_W'(rbin_next)));
    level_next = wbin - rbin_next;
  end

  always_ff @(posedge R_CLK) begin
    if (R_RST) begin
      rbin         <= '0;
      R_PTR_GRAY   <= '0;
      EMPTY        <= 1'b1;
      ALMOST_EMPTY <= 1'b1;
      R_LEVEL      <= '0;
      UNDERFLOW    <= 1'b0;
    end else begin
      rbin         <= rbin_next;
      R_PTR_GRAY   <= rgray_next;
      EMPTY        <= (rgray_next == R_WPTR_GRAY);
      ALMOST_EMPTY <= (level_next <= AE_THRESH);
      R_LEVEL      <= level_next;
      if (R_INC && EMPTY) begin
        UNDERFLOW <= 1'b1;
      end else if (CLR_UFLOW) begin
        UNDERFLOW <= 1'b0;
      end
    end
  end

  assign R_ADDR = rbin[ADDR_WIDTH-1:0];

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Parametrised read-side controller for the asynchronous FIFO, running entirely in the read clock domain. Holds the binary read pointer and drives the RAM read address. Publishes a registered gray read pointer for the write-side synchroniser. Generates registered EMPTY, ALMOST_EMPTY, occupancy level and a sticky UNDERFLOW flag from the write pointer, which arrives already synchronised into the read domain.

Parameters:
ADDR_WIDTH, 3, RAM address width; FIFO depth DEPTH = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
AEMPTY_LEVEL, 1, ALMOST_EMPTY asserts when occupancy <= AEMPTY_LEVEL; legal range 0..DEPTH-1.

Ports:
R_CLK  input  1  read-domain clock, all logic on rising edge
R_RST  input  1  reset, synchronous, active-high
R_INC  input  1  pop request; honoured only when EMPTY=0
CLR_UFLOW  input  1  clears sticky UNDERFLOW
R_WPTR_GRAY  input  ADDR_WIDTH+1  write pointer, gray coded, already synchronised to R_CLK
R_ADDR  output  ADDR_WIDTH  RAM read address = low bits of binary read pointer
R_PTR_GRAY  output  ADDR_WIDTH+1  registered gray read pointer, to write-side synchroniser
EMPTY  output  1  registered empty flag
ALMOST_EMPTY  output  1  registered, occupancy <= AEMPTY_LEVEL
R_LEVEL  output  ADDR_WIDTH+1  registered occupancy, 0..DEPTH
UNDERFLOW  output  1  sticky, set on pop attempt while EMPTY

Behaviour:
- Reset (R_RST=1 at an R_CLK edge), synchronous and dominant over all other inputs:
  - rbin = 0, R_ADDR = 0, R_PTR_GRAY = 0, R_LEVEL = 0.
  - EMPTY = 1, ALMOST_EMPTY = 1, UNDERFLOW = 0.
  - Asserting reset mid-operation discards pointer state on that edge; no partial pop.
- Pop rule:
  - pop = R_INC & ~EMPTY.
  - rbin_next = rbin + pop, modulo 2**(ADDR_WIDTH+1), wrapping naturally.
  - R_ADDR = rbin[ADDR_WIDTH-1:0].
- R_PTR_GRAY is registered as bin2gray(rbin_next). Binary and gray pointers therefore update on the same edge, with no one-cycle gray lag.
- Write pointer conversion: wbin = gray2bin(R_WPTR_GRAY), combinational, sampled each cycle.
- EMPTY register: loads (bin2gray(rbin_next) == R_WPTR_GRAY).
  - Deasserts one cycle after the synchronised write pointer moves.
  - Asserts on the same edge as the pop that consumes the last word.
- R_LEVEL register: loads (wbin - rbin_next) mod 2**(ADDR_WIDTH+1).
  - Values above DEPTH are impossible with a coherent write pointer; no correction is applied.
- ALMOST_EMPTY register: loads (level_next <= AEMPTY_LEVEL).
  - Implies ALMOST_EMPTY=1 whenever EMPTY=1.
- Simultaneous pop and write-pointer advance in one cycle: level is unchanged and EMPTY stays 0.
- UNDERFLOW:
  - Set on the edge where R_INC=1 and EMPTY=1; the pointer holds.
  - Cleared on the edge where CLR_UFLOW=1.
  - Set wins when set and clear occur together.
- Full condition (level = DEPTH) is legal on the read side; pops proceed normally.
- All outputs are registered; nothing combinational goes from R_INC to any output.

Decomposition:
- Shared package fifo_pkg:
  - bin2gray and gray2bin functions, parametrised by width.
  - Constant helper for pointer width (ADDR_WIDTH+1).
  - The write-side controller reuses the same package.
- Pointer and flag logic stays in one module.
- Natural sub-module: fifo_gray2bin, a combinational converter for R_WPTR_GRAY. It is optional if the package function is used.

Test Plan:
All scenarios use ADDR_WIDTH=3, AEMPTY_LEVEL=1.
1. Reset: hold R_RST=1 for 2 cycles with R_INC=1 -> R_ADDR=0, R_PTR_GRAY=0000, EMPTY=1, ALMOST_EMPTY=1, R_LEVEL=0, UNDERFLOW=0 after each edge.
2. Drain from 3: R_WPTR_GRAY=0010 (bin 3) -> next cycle EMPTY=0, R_LEVEL=3, ALMOST_EMPTY=0. Then pop 3 times -> R_LEVEL 2,1,0; ALMOST_EMPTY=1 from level 1; EMPTY=1 after third pop; R_ADDR=3; R_PTR_GRAY=0010.
3. Underflow: EMPTY=1 and R_INC=1 -> R_ADDR unchanged, UNDERFLOW=1 next cycle. CLR_UFLOW=1 alone -> 0. CLR_UFLOW with a new underflow in the same cycle -> stays 1.
4. Wrap and full: R_WPTR_GRAY=1100 (bin 8) -> R_LEVEL=8. Pop 8 times -> R_ADDR steps 0..7 then wraps to 0, R_PTR_GRAY=1100, EMPTY=1, R_LEVEL=0. Repeat with write bin 16 (gray 0000) -> pointer wraps to 0000 correctly.
5. Concurrent: level 1, R_INC=1 while R_WPTR_GRAY advances by one code in the same cycle -> R_LEVEL stays 1, EMPTY=0, R_ADDR incremented.
6. Reset mid-drain: level 5, assert R_RST for one cycle during pops -> all outputs return to reset values on that edge. After release with write pointer at bin 5, next cycle R_LEVEL=5.
